// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks the single-shot I2C ADC driver through a fixed list
// of MUX codes once per scan, keeps the latest sample per slot, and flags lost
// period ticks (overrun) and hung conversions (timeout).
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for a pending period tick or a single-shot request
//   SETUP | MUX code for the current slot is on adc_mux_o, enable low
//   REQ   | enable high, waiting for the ADC to drop a stale ready
//   CONV  | enable high, waiting for ready; captures data on the ready edge
//   REL   | enable low for two cycles so the ADC returns to idle
//   NEXT  | advance to the next slot, or finish the scan
module adc_scan_sequencer #(
  parameter int unsigned          NUM_CH         = 2,
  parameter logic [NUM_CH*3-1:0]  MUX_LIST       = {3'b000, 3'b100},
  parameter int unsigned          PERIOD_CYCLES  = 27000,
  parameter int unsigned          TIMEOUT_CYCLES = 2700000,
  localparam int unsigned         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   run_i,
  input  logic                   single_i,
  input  logic                   clr_err_i,
  output logic                   adc_enable_o,
  output logic [2:0]             adc_mux_o,
  input  logic [15:0]            adc_data_i,
  input  logic                   adc_ready_i,
  output logic [NUM_CH*16-1:0]   sample_o,
  output logic                   sample_valid_o,
  output logic [CH_W-1:0]        sample_ch_o,
  output logic                   scan_done_o,
  output logic [15:0]            scan_count_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   timeout_o
);

  localparam int unsigned    PER_W   = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned    WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_CONV,
    S_REL,
    S_NEXT
  } state_e;

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [2:0]             mux_q, mux_d;
  logic                   en_q, en_d;
  logic [NUM_CH*16-1:0]   sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic [CH_W-1:0]        sample_ch_q, sample_ch_d;
  logic                   done_q, done_d;
  logic [15:0]            scan_cnt_q, scan_cnt_d;
  logic                   rel_q, rel_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [PER_W-1:0]       per_q, per_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  logic                   take;
  logic                   wd_fire;
  logic                   per_tick;
  logic                   ovr_evt;

  // Period down-counter: parked at its reload value while run_i is low, so the
  // first tick comes a full period after scanning is enabled.
  always_comb begin
    per_tick = run_i && (per_q == '0);
    if (!run_i || per_q == '0) begin
      per_d = PER_W'(PERIOD_CYCLES - 1);
    end else begin
      per_d = per_q - 1'b1;
    end
  end

  // Pending tick and sticky error flags; a new event wins over a clear.
  always_comb begin
    ovr_evt = per_tick && pending_q && !take;
    if (!run_i) begin
      pending_d = 1'b0;
    end else if (per_tick) begin
      pending_d = 1'b1;
    end else if (take) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    overrun_d = clr_err_i ? 1'b0 : overrun_q;
    if (ovr_evt) overrun_d = 1'b1;
    timeout_d = clr_err_i ? 1'b0 : timeout_q;
    if (wd_fire) timeout_d = 1'b1;
  end

  // Scan FSM next-state and datapath. The MUX code is loaded on entry to SETUP,
  // one cycle before enable rises, and is only reloaded after REL.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    mux_d       = mux_q;
    en_d        = en_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    sample_ch_d = sample_ch_q;
    done_d      = 1'b0;
    scan_cnt_d  = scan_cnt_q;
    rel_d       = rel_q;
    wd_d        = wd_q;
    take        = 1'b0;
    wd_fire     = 1'b0;

    if ((state_q == S_REQ || state_q == S_CONV) && wd_q != '0) begin
      wd_d = wd_q - 1'b1;
      if (wd_q == WD_W'(1)) wd_fire = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q || single_i) begin
          take    = 1'b1;
          ch_d    = '0;
          mux_d   = MUX_LIST[2:0];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        en_d    = 1'b1;
        wd_d    = WD_W'(TIMEOUT_CYCLES);
        state_d = S_REQ;
      end
      S_REQ: begin
        if (!adc_ready_i) state_d = S_CONV;
      end
      S_CONV: begin
        if (adc_ready_i) begin
          sample_d[16*int'(ch_q) +: 16] = adc_data_i;
          valid_d     = 1'b1;
          sample_ch_d = ch_q;
          en_d        = 1'b0;
          rel_d       = 1'b0;
          state_d     = S_REL;
        end
      end
      S_REL: begin
        if (rel_q) begin
          state_d = S_NEXT;
        end else begin
          rel_d = 1'b1;
        end
      end
      S_NEXT: begin
        if (ch_q == LAST_CH) begin
          done_d     = 1'b1;
          scan_cnt_d = scan_cnt_q + 16'd1;
          state_d    = S_IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          mux_d   = MUX_LIST[3*int'(ch_q + 1'b1) +: 3];
          state_d = S_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops enable immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      mux_q       <= '0;
      en_q        <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      sample_ch_q <= '0;
      done_q      <= 1'b0;
      scan_cnt_q  <= '0;
      rel_q       <= 1'b0;
      wd_q        <= '0;
      per_q       <= PER_W'(PERIOD_CYCLES - 1);
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      mux_q       <= mux_d;
      en_q        <= en_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      sample_ch_q <= sample_ch_d;
      done_q      <= done_d;
      scan_cnt_q  <= scan_cnt_d;
      rel_q       <= rel_d;
      wd_q        <= wd_d;
      per_q       <= per_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign adc_enable_o   = en_q;
  assign adc_mux_o      = mux_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign sample_ch_o    = sample_ch_q;
  assign scan_done_o    = done_q;
  assign scan_count_o   = scan_cnt_q;
  assign busy_o         = (state_q != S_IDLE);
  assign overrun_o      = overrun_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: behavioural single-shot ADC plus a monitor that
// predicts slot order, captured data, latency and scan counts from the
// sequencing rules.
module tb_adc_scan_sequencer;

  localparam int NUM_CH  = 2;
  localparam int CH_W    = 1;
  localparam int PERIOD  = 50;
  localparam int TMO     = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 run_i;
  logic                 single_i;
  logic                 clr_err_i;
  logic                 adc_enable_o;
  logic [2:0]           adc_mux_o;
  logic [15:0]          adc_data_i;
  logic                 adc_ready_i;
  logic [NUM_CH*16-1:0] sample_o;
  logic                 sample_valid_o;
  logic [CH_W-1:0]      sample_ch_o;
  logic                 scan_done_o;
  logic [15:0]          scan_count_o;
  logic                 busy_o;
  logic                 overrun_o;
  logic                 timeout_o;

  adc_scan_sequencer #(
    .NUM_CH(NUM_CH),
    .MUX_LIST({3'b000, 3'b100}),
    .PERIOD_CYCLES(PERIOD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .single_i(single_i),
    .clr_err_i(clr_err_i), .adc_enable_o(adc_enable_o), .adc_mux_o(adc_mux_o),
    .adc_data_i(adc_data_i), .adc_ready_i(adc_ready_i), .sample_o(sample_o),
    .sample_valid_o(sample_valid_o), .sample_ch_o(sample_ch_o),
    .scan_done_o(scan_done_o), .scan_count_o(scan_count_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [5:0]           muxes_v = {3'b000, 3'b100};
  int                   lat_cyc    = 3;
  int                   stale_cyc  = 0;
  bit                   fixed_data = 1'b1;
  logic [15:0]          conv_d_q[$];
  logic [2:0]           conv_m_q[$];
  int                   rdy_cyc    = -10;
  int                   exp_ch     = 0;
  int                   exp_scans  = 0;
  int                   last_cyc   = -10;
  logic [NUM_CH*16-1:0] exp_vec    = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // Single-shot ADC: ready stays high until the next enable; stale_cyc models a
  // slow release of that old ready.
  initial begin
    logic [2:0]  m;
    logic [15:0] d;
    adc_ready_i = 1'b0;
    adc_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (adc_enable_o) begin
        m = adc_mux_o;
        repeat (stale_cyc) @(negedge clk_i);
        adc_ready_i = 1'b0;
        repeat (lat_cyc) @(negedge clk_i);
        if (fixed_data) d = (m == 3'b100) ? 16'h1234 : ((m == 3'b000) ? 16'hFEDC : 16'h0000);
        else            d = 16'($urandom);
        adc_data_i  = d;
        adc_ready_i = 1'b1;
        conv_d_q.push_back(d);
        conv_m_q.push_back(m);
        rdy_cyc = cyc;
        while (adc_enable_o) @(negedge clk_i);
      end
    end
  end

  // Reference monitor: slots in list order, capture one cycle after ready,
  // scan_done three cycles after the last slot, count increments by one.
  initial begin
    logic [15:0] d;
    logic [2:0]  m;
    int          slot;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (adc_enable_o)
          check("mux_code", 64'(adc_mux_o), 64'(muxes_v[exp_ch*3 +: 3]));
        if (sample_valid_o) begin
          check("valid_has_conv", 64'(conv_d_q.size() > 0), 64'd1);
          if (conv_d_q.size() > 0) begin
            d = conv_d_q.pop_front();
            m = conv_m_q.pop_front();
            slot = -1;
            for (int k = 0; k < NUM_CH; k++) if (muxes_v[k*3 +: 3] == m) slot = k;
            check("valid_latency", 64'(cyc), 64'(rdy_cyc + 1));
            check("sample_ch_order", 64'(sample_ch_o), 64'(exp_ch));
            check("sample_ch_mux", 64'(sample_ch_o), 64'(slot));
            if (slot >= 0) exp_vec[slot*16 +: 16] = d;
            check("sample_vec", 64'(sample_o), 64'(exp_vec));
          end
          if (exp_ch == NUM_CH - 1) last_cyc = cyc;
          exp_ch = (exp_ch + 1) % NUM_CH;
        end
        if (scan_done_o) begin
          exp_scans++;
          check("done_latency", 64'(cyc), 64'(last_cyc + 3));
          check("scan_count", 64'(scan_count_o), 64'(exp_scans[15:0]));
        end
      end
    end
  end

  task automatic pulse_single();
    @(negedge clk_i); single_i = 1'b1;
    @(negedge clk_i); single_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!scan_done_o && n < budget);
    check(tag, 64'(scan_done_o), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 64'(busy_o), 64'd0);
  endtask

  task automatic wait_enable(input string tag, input int budget);
    int n = 0;
    while (!adc_enable_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 64'(adc_enable_o), 64'd1);
  endtask

  task automatic quiet(input string tag, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (adc_enable_o || busy_o) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] base_cnt;
    int          n;
    rst_ni = 1'b0; run_i = 1'b0; single_i = 1'b0; clr_err_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    check("rst_enable", 64'(adc_enable_o), 64'd0);
    check("rst_mux", 64'(adc_mux_o), 64'd0);
    check("rst_sample", 64'(sample_o), 64'd0);
    check("rst_valid", 64'(sample_valid_o), 64'd0);
    check("rst_ch", 64'(sample_ch_o), 64'd0);
    check("rst_done", 64'(scan_done_o), 64'd0);
    check("rst_count", 64'(scan_count_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_overrun", 64'(overrun_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    quiet("idle_100", 100);

    // Directed single scan with fixed per-MUX data.
    fixed_data = 1'b1; lat_cyc = 3; stale_cyc = 0;
    pulse_single();
    wait_done("single_done", 200);
    check("single_samples", 64'(sample_o), 64'h0000_0000_FEDC_1234);
    check("single_count", 64'(scan_count_o), 64'd1);

    // Ready left high from the previous conversion for 5 cycles.
    fixed_data = 1'b0; stale_cyc = 5;
    pulse_single();
    wait_done("stale_done", 200);
    stale_cyc = 0;

    // Randomised single scans.
    for (int i = 0; i < 4; i++) begin
      lat_cyc   = $urandom_range(1, 6);
      stale_cyc = $urandom_range(0, 3);
      pulse_single();
      wait_done("rand_done", 200);
    end
    stale_cyc = 0;
    check("rand_no_timeout", 64'(timeout_o), 64'd0);
    check("rand_no_overrun", 64'(overrun_o), 64'd0);

    // First periodic scan starts one cycle after a full period.
    lat_cyc = 3;
    @(negedge clk_i); run_i = 1'b1;
    repeat (PERIOD) @(negedge clk_i);
    check("tick_not_early", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    check("tick_start", 64'(busy_o), 64'd1);
    repeat (170) @(negedge clk_i);
    run_i = 1'b0;
    wait_idle("periodic_idle", 100);
    check("periodic_no_overrun", 64'(overrun_o), 64'd0);
    quiet("periodic_stop", 80);

    // Conversions longer than the period: ticks get lost.
    base_cnt = scan_count_o;
    lat_cyc = 80;
    @(negedge clk_i); run_i = 1'b1;
    repeat (420) @(negedge clk_i);
    check("overrun_set", 64'(overrun_o), 64'd1);
    check("overrun_scans_continue", 64'(scan_count_o > base_cnt), 64'd1);
    run_i = 1'b0;
    wait_idle("overrun_idle", 400);
    check("slow_timeout_set", 64'(timeout_o), 64'd1);
    @(negedge clk_i); clr_err_i = 1'b1;
    @(negedge clk_i); clr_err_i = 1'b0;
    check("clr_overrun", 64'(overrun_o), 64'd0);
    check("clr_timeout", 64'(timeout_o), 64'd0);

    // Watchdog: fires after TMO cycles with enable high; clear on the same edge loses.
    lat_cyc = 40;
    pulse_single();
    wait_enable("tmo_enable", 20);
    repeat (TMO - 2) @(negedge clk_i);
    clr_err_i = 1'b1;
    @(negedge clk_i);
    check("tmo_not_early", 64'(timeout_o), 64'd0);
    @(negedge clk_i);
    clr_err_i = 1'b0;
    check("tmo_set_wins", 64'(timeout_o), 64'd1);
    check("tmo_enable_held", 64'(adc_enable_o), 64'd1);
    wait_done("tmo_late_capture", 200);

    // single_i during a scan is ignored.
    lat_cyc = 12;
    base_cnt = scan_count_o;
    pulse_single();
    repeat (8) @(negedge clk_i);
    pulse_single();
    wait_done("busy_single_done", 200);
    quiet("busy_single_ignored", 60);
    check("busy_single_count", 64'(scan_count_o), 64'(base_cnt + 16'd1));

    // run_i dropped mid-scan with a tick already pending.
    lat_cyc = 30;
    @(negedge clk_i); run_i = 1'b1;
    n = 0;
    while (!(sample_valid_o && sample_ch_o == 1'b1) && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check("drop_last_valid", 64'(sample_valid_o), 64'd1);
    run_i = 1'b0;
    wait_done("drop_done", 20);
    quiet("drop_stays_idle", 100);
    check("drop_no_overrun", 64'(overrun_o), 64'd0);

    // Reset mid-conversion drops enable without a clock edge.
    lat_cyc = 20;
    pulse_single();
    wait_enable("rst_mid_enable", 20);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_enable_drop", 64'(adc_enable_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_count", 64'(scan_count_o), 64'd0);
    check("rst_mid_sample", 64'(sample_o), 64'd0);
    check("rst_mid_timeout", 64'(timeout_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
